// File: rtl/ffcp_rx_reorder_pkg.sv
// Shared FFCP constants and types used by the receive reorder buffer.
package ffcp_rx_reorder_pkg;

    localparam int unsigned BYTE_LEN        = 8;
    localparam int unsigned FFCP_DATA_LEN   = 769;
    localparam int unsigned FFCP_WINDOW_LEN = 8;
    localparam int unsigned FFCP_INDEX_LEN  = 6;
    localparam int unsigned FFCP_TYPE_LEN   = 2;

    localparam logic [FFCP_TYPE_LEN-1:0] FFCP_TYPE_MSG = 2'd0;
    localparam logic [FFCP_TYPE_LEN-1:0] FFCP_TYPE_SYN = 2'd1;
    localparam logic [FFCP_TYPE_LEN-1:0] FFCP_TYPE_ACK = 2'd2;

    // Each slot occupies a 1024-byte region so the address is a plain concatenation.
    localparam int unsigned SLOT_CNT_LEN = 10;

    typedef enum logic {
        StIdle,
        StDrain
    } drain_state_e;

    // Modulo-2^FFCP_INDEX_LEN distance from head to idx.
    function automatic logic [FFCP_INDEX_LEN-1:0] index_dist(
        input logic [FFCP_INDEX_LEN-1:0] idx,
        input logic [FFCP_INDEX_LEN-1:0] head
    );
        return idx - head;
    endfunction

endpackage

// File: rtl/ffcp_rx_reorder_ram.sv
// Simple dual-port byte RAM with a pipelined registered read of LATENCY cycles.
module ffcp_rx_reorder_ram #(
    parameter int unsigned DEPTH   = 8192,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] pipe_q [LATENCY];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port: first stage captures the array, remaining stages add latency.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            pipe_q[0] <= mem[rd_addr_i];
        end
        for (int i = 1; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rd_data_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/ffcp_rx_reorder.sv
// Receive-side FFCP reorder buffer: stores in-window payloads per slot and
// drains completed slots strictly in index order as a byte stream.
module ffcp_rx_reorder
    import ffcp_rx_reorder_pkg::*;
#(
    parameter int unsigned DATA_LEN    = FFCP_DATA_LEN,
    parameter int unsigned WINDOW_LEN  = FFCP_WINDOW_LEN,
    parameter int unsigned RAM_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      metadata_inclk_i,
    input  logic [FFCP_TYPE_LEN-1:0]  in_type_i,
    input  logic [FFCP_INDEX_LEN-1:0] in_index_i,
    input  logic                      inclk_i,
    input  logic [BYTE_LEN-1:0]       in_i,
    input  logic                      in_done_i,
    input  logic                      readclk_i,
    output logic                      rdy_o,
    output logic                      outclk_o,
    output logic [BYTE_LEN-1:0]       out_o,
    output logic                      out_done_o,
    output logic [FFCP_INDEX_LEN-1:0] head_index_o
);

    localparam int unsigned SlotW = $clog2(WINDOW_LEN);
    localparam int unsigned CntW  = SLOT_CNT_LEN;
    localparam int unsigned AddrW = SlotW + CntW;

    localparam logic [CntW-1:0]           LastCnt    = CntW'(DATA_LEN - 1);
    localparam logic [CntW:0]             DataLenExt = (CntW + 1)'(DATA_LEN);
    localparam logic [CntW-1:0]           CntOne     = CntW'(1);
    localparam logic [FFCP_INDEX_LEN-1:0] IdxOne     = FFCP_INDEX_LEN'(1);
    localparam logic [FFCP_INDEX_LEN:0]   WinLen     = (FFCP_INDEX_LEN + 1)'(WINDOW_LEN);

    logic [WINDOW_LEN-1:0]     valid_q, valid_d;
    logic [FFCP_INDEX_LEN-1:0] head_index_q;
    drain_state_e              state_q;
    logic [CntW-1:0]           rcnt_q;

    logic                      accept_q, accept_d;
    logic [SlotW-1:0]          wslot_q, wslot_d;
    logic [CntW-1:0]           wcnt_q, wcnt_d;

    logic                      syn;
    logic [SlotW-1:0]          in_slot;
    logic [SlotW-1:0]          head_slot;
    logic                      in_win;
    logic                      wr_en;
    logic                      wr_done;
    logic                      rd_issue;
    logic                      drain_last;

    logic [RAM_LATENCY-1:0]    dly_vld_q;
    logic [RAM_LATENCY-1:0]    dly_last_q;
    logic [BYTE_LEN-1:0]       rd_data;

    assign syn       = metadata_inclk_i && (in_type_i == FFCP_TYPE_SYN);
    assign in_slot   = in_index_i[SlotW-1:0];
    assign head_slot = head_index_q[SlotW-1:0];
    assign in_win    = {1'b0, index_dist(in_index_i, head_index_q)} < WinLen;

    // A SYN in the same cycle aborts the drain, so its read never enters the pipeline.
    assign rd_issue   = (state_q == StDrain) && readclk_i && !syn;
    assign drain_last = rd_issue && (rcnt_q == LastCnt);

    // Write-path next state: accept decision on metadata, byte counting on payload.
    always_comb begin
        accept_d = accept_q;
        wslot_d  = wslot_q;
        wcnt_d   = wcnt_q;
        wr_en    = 1'b0;
        wr_done  = 1'b0;
        if (metadata_inclk_i) begin
            wcnt_d = '0;
            unique case (in_type_i)
                FFCP_TYPE_SYN: begin
                    accept_d = 1'b1;
                    wslot_d  = '0;
                end
                FFCP_TYPE_MSG: begin
                    accept_d = in_win && !valid_q[in_slot];
                    wslot_d  = in_slot;
                end
                default: accept_d = 1'b0;
            endcase
        end else if (accept_q) begin
            if (inclk_i) begin
                // Overlong payloads must not spill past the slot's data region.
                wr_en  = {1'b0, wcnt_q} < DataLenExt;
                wcnt_d = wcnt_q + CntOne;
            end
            if (in_done_i) begin
                accept_d = 1'b0;
                wr_done  = (wcnt_q == LastCnt);
            end
        end
    end

    // Write-path state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            accept_q <= 1'b0;
            wslot_q  <= '0;
            wcnt_q   <= '0;
        end else begin
            accept_q <= accept_d;
            wslot_q  <= wslot_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Slot valid bits: set on complete write, cleared on drain end, wiped by SYN.
    always_comb begin
        valid_d = valid_q;
        if (drain_last) begin
            valid_d[head_slot] = 1'b0;
        end
        if (wr_done) begin
            valid_d[wslot_q] = 1'b1;
        end
        if (syn) begin
            valid_d = '0;
        end
    end

    // Valid bit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Drain FSM: waits for the head slot, then reads it out one byte per readclk.
    always_ff @(posedge clk) begin
        if (rst || syn) begin
            state_q      <= StIdle;
            head_index_q <= '0;
            rcnt_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid_q[head_slot]) begin
                        state_q <= StDrain;
                        rcnt_q  <= '0;
                    end
                end
                StDrain: begin
                    if (readclk_i) begin
                        rcnt_q <= rcnt_q + CntOne;
                        if (rcnt_q == LastCnt) begin
                            head_index_q <= head_index_q + IdxOne;
                            state_q      <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

    // Strobe/done delay line matching the RAM read latency; flushed on abort.
    always_ff @(posedge clk) begin
        if (rst || syn) begin
            dly_vld_q  <= '0;
            dly_last_q <= '0;
        end else begin
            dly_vld_q  <= RAM_LATENCY'({dly_vld_q, rd_issue});
            dly_last_q <= RAM_LATENCY'({dly_last_q, drain_last});
        end
    end

    ffcp_rx_reorder_ram #(
        .DEPTH   (WINDOW_LEN * 1024),
        .ADDR_W  (AddrW),
        .DATA_W  (BYTE_LEN),
        .LATENCY (RAM_LATENCY)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i ({wslot_q, wcnt_q}),
        .wr_data_i (in_i),
        .rd_en_i   (rd_issue),
        .rd_addr_i ({head_slot, rcnt_q}),
        .rd_data_o (rd_data)
    );

    assign rdy_o        = (state_q == StDrain);
    assign outclk_o     = dly_vld_q[RAM_LATENCY-1];
    assign out_done_o   = dly_last_q[RAM_LATENCY-1];
    // RAM output is undefined outside a strobe, so hold the byte at zero there.
    assign out_o        = dly_vld_q[RAM_LATENCY-1] ? rd_data : '0;
    assign head_index_o = head_index_q;

endmodule

// File: tb/tb_ffcp_rx_reorder.sv
// Scoreboard bench for ffcp_rx_reorder: expected bytes are queued as packets
// are sent and compared as the DUT strobes them out.
module tb_ffcp_rx_reorder;
    import ffcp_rx_reorder_pkg::*;

    localparam int DLEN = FFCP_DATA_LEN;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      metadata_inclk = 1'b0;
    logic [FFCP_TYPE_LEN-1:0]  in_type = '0;
    logic [FFCP_INDEX_LEN-1:0] in_index = '0;
    logic                      inclk = 1'b0;
    logic [BYTE_LEN-1:0]       in_byte = '0;
    logic                      in_done = 1'b0;
    logic                      readclk = 1'b0;
    logic                      rdy_o;
    logic                      outclk_o;
    logic [BYTE_LEN-1:0]       out_o;
    logic                      out_done_o;
    logic [FFCP_INDEX_LEN-1:0] head_index_o;

    logic [8:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic       saw_rdy = 1'b0;

    always #5 clk = ~clk;

    ffcp_rx_reorder dut (
        .clk              (clk),
        .rst              (rst),
        .metadata_inclk_i (metadata_inclk),
        .in_type_i        (in_type),
        .in_index_i       (in_index),
        .inclk_i          (inclk),
        .in_i             (in_byte),
        .in_done_i        (in_done),
        .readclk_i        (readclk),
        .rdy_o            (rdy_o),
        .outclk_o         (outclk_o),
        .out_o            (out_o),
        .out_done_o       (out_done_o),
        .head_index_o     (head_index_o)
    );

    function automatic logic [7:0] pbyte(input int seed, input int k);
        return 8'((seed * 53 + k) & 255);
    endfunction

    // Scoreboard: every output strobe must match the head of the expected queue.
    always @(negedge clk) begin : mon
        logic [8:0] e;
        if (outclk_o) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_unexpected: got byte %02h done %0b, required no output",
                         out_o, out_done_o);
            end else begin
                e = exp_q.pop_front();
                if ({out_done_o, out_o} !== e) begin
                    n_err++;
                    $display("FAIL out_byte: got byte %02h done %0b, required byte %02h done %0b",
                             out_o, out_done_o, e[7:0], e[8]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rdy_o) saw_rdy = 1'b1;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input logic [FFCP_TYPE_LEN-1:0] typ, input int idx, input int seed,
                            input int len);
        metadata_inclk = 1'b1;
        in_type        = typ;
        in_index       = FFCP_INDEX_LEN'(idx);
        cyc(1);
        metadata_inclk = 1'b0;
        for (int k = 0; k < len; k++) begin
            inclk   = 1'b1;
            in_byte = pbyte(seed, k);
            in_done = (k == len - 1);
            cyc(1);
        end
        inclk   = 1'b0;
        in_done = 1'b0;
    endtask

    task automatic push_pkt(input int seed, input int n, input logic with_done);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({with_done && (k == DLEN - 1), pbyte(seed, k)});
        end
    endtask

    task automatic wait_empty(input string name, input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            cyc(1);
            t++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d bytes still outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        cyc(4);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(3);
        n_cmp += 5;
        if (rdy_o !== 1'b0) begin
            n_err++; $display("FAIL reset_rdy: got %b, required 0", rdy_o);
        end
        if (outclk_o !== 1'b0) begin
            n_err++; $display("FAIL reset_outclk: got %b, required 0", outclk_o);
        end
        if (out_done_o !== 1'b0) begin
            n_err++; $display("FAIL reset_out_done: got %b, required 0", out_done_o);
        end
        if (out_o !== 8'h00) begin
            n_err++; $display("FAIL reset_out: got %02h, required 00", out_o);
        end
        if (head_index_o !== 6'd0) begin
            n_err++; $display("FAIL reset_head: got %0d, required 0", head_index_o);
        end
        rst     = 1'b0;
        readclk = 1'b1;
        saw_rdy = 1'b0;
        cyc(6);
        n_cmp++;
        if (saw_rdy !== 1'b0) begin
            n_err++; $display("FAIL reset_idle_rdy: got rdy 1, required 0");
        end
    endtask

    task automatic test_in_order;
        readclk = 1'b1;
        push_pkt(1, DLEN, 1'b1);
        send_pkt(FFCP_TYPE_SYN, 0, 1, DLEN);
        push_pkt(2, DLEN, 1'b1);
        send_pkt(FFCP_TYPE_MSG, 1, 2, DLEN);
        wait_empty("in_order", 5000);
        n_cmp++;
        if (head_index_o !== 6'd2) begin
            n_err++; $display("FAIL in_order_head: got %0d, required 2", head_index_o);
        end
    endtask

    task automatic test_reorder;
        readclk = 1'b1;
        push_pkt(3, DLEN, 1'b1);
        send_pkt(FFCP_TYPE_SYN, 0, 3, DLEN);
        wait_empty("reorder_syn", 3000);
        n_cmp++;
        if (head_index_o !== 6'd1) begin
            n_err++; $display("FAIL reorder_head_syn: got %0d, required 1", head_index_o);
        end
        saw_rdy = 1'b0;
        send_pkt(FFCP_TYPE_MSG, 3, 4, DLEN);
        send_pkt(FFCP_TYPE_MSG, 2, 5, DLEN);
        cyc(5);
        n_cmp++;
        if (saw_rdy !== 1'b0) begin
            n_err++; $display("FAIL reorder_early_rdy: got rdy 1 before index 1, required 0");
        end
        push_pkt(6, DLEN, 1'b1);
        push_pkt(5, DLEN, 1'b1);
        push_pkt(4, DLEN, 1'b1);
        send_pkt(FFCP_TYPE_MSG, 1, 6, DLEN);
        wait_empty("reorder", 5000);
        n_cmp++;
        if (head_index_o !== 6'd4) begin
            n_err++; $display("FAIL reorder_head: got %0d, required 4", head_index_o);
        end
    endtask

    task automatic test_dup_window;
        readclk = 1'b1;
        saw_rdy = 1'b0;
        send_pkt(FFCP_TYPE_MSG, 2, 32, DLEN);
        send_pkt(FFCP_TYPE_MSG, 12, 33, DLEN);
        send_pkt(FFCP_TYPE_ACK, 4, 34, DLEN);
        cyc(5);
        n_cmp += 2;
        if (saw_rdy !== 1'b0) begin
            n_err++; $display("FAIL dup_window_rdy: got rdy 1, required 0");
        end
        if (head_index_o !== 6'd4) begin
            n_err++; $display("FAIL dup_window_head: got %0d, required 4", head_index_o);
        end
        send_pkt(FFCP_TYPE_MSG, 5, 7, DLEN);
        send_pkt(FFCP_TYPE_MSG, 5, 9, DLEN);
        cyc(5);
        n_cmp++;
        if (saw_rdy !== 1'b0) begin
            n_err++; $display("FAIL dup_buffered_rdy: got rdy 1 with head missing, required 0");
        end
        push_pkt(8, DLEN, 1'b1);
        push_pkt(7, DLEN, 1'b1);
        send_pkt(FFCP_TYPE_MSG, 4, 8, DLEN);
        wait_empty("dup", 5000);
        n_cmp++;
        if (head_index_o !== 6'd6) begin
            n_err++; $display("FAIL dup_head: got %0d, required 6", head_index_o);
        end
    endtask

    task automatic test_wrap;
        readclk = 1'b1;
        for (int i = 6; i < 62; i++) begin
            push_pkt(100 + i, DLEN, 1'b1);
            send_pkt(FFCP_TYPE_MSG, i, 100 + i, DLEN);
        end
        wait_empty("wrap_advance", 5000);
        n_cmp++;
        if (head_index_o !== 6'd62) begin
            n_err++; $display("FAIL wrap_head_62: got %0d, required 62", head_index_o);
        end
        saw_rdy = 1'b0;
        send_pkt(FFCP_TYPE_MSG, 63, 200, DLEN);
        send_pkt(FFCP_TYPE_MSG, 0, 201, DLEN);
        send_pkt(FFCP_TYPE_MSG, 1, 202, DLEN);
        cyc(5);
        n_cmp++;
        if (saw_rdy !== 1'b0) begin
            n_err++; $display("FAIL wrap_early_rdy: got rdy 1 before index 62, required 0");
        end
        push_pkt(199, DLEN, 1'b1);
        push_pkt(200, DLEN, 1'b1);
        push_pkt(201, DLEN, 1'b1);
        push_pkt(202, DLEN, 1'b1);
        send_pkt(FFCP_TYPE_MSG, 62, 199, DLEN);
        wait_empty("wrap", 6000);
        n_cmp++;
        if (head_index_o !== 6'd2) begin
            n_err++; $display("FAIL wrap_head: got %0d, required 2", head_index_o);
        end
    endtask

    task automatic test_truncated;
        readclk = 1'b1;
        saw_rdy = 1'b0;
        send_pkt(FFCP_TYPE_MSG, 2, 50, 101);
        cyc(6);
        n_cmp += 2;
        if (saw_rdy !== 1'b0) begin
            n_err++; $display("FAIL trunc_rdy: got rdy 1, required 0");
        end
        if (head_index_o !== 6'd2) begin
            n_err++; $display("FAIL trunc_head: got %0d, required 2", head_index_o);
        end
        push_pkt(51, DLEN, 1'b1);
        send_pkt(FFCP_TYPE_MSG, 2, 51, DLEN);
        wait_empty("trunc_resend", 3000);
        n_cmp++;
        if (head_index_o !== 6'd3) begin
            n_err++; $display("FAIL trunc_resend_head: got %0d, required 3", head_index_o);
        end
    endtask

    task automatic test_syn_mid_drain;
        int t = 0;
        readclk = 1'b0;
        send_pkt(FFCP_TYPE_MSG, 3, 60, DLEN);
        while (!rdy_o && t < 50) begin
            cyc(1);
            t++;
        end
        n_cmp++;
        if (rdy_o !== 1'b1) begin
            n_err++; $display("FAIL syn_rdy_rise: got rdy %b, required 1", rdy_o);
        end
        // 300 reads issued; the last one is still in the pipeline when SYN lands.
        push_pkt(60, 299, 1'b0);
        readclk = 1'b1;
        cyc(300);
        readclk = 1'b0;
        send_pkt(FFCP_TYPE_SYN, 0, 61, DLEN);
        cyc(4);
        n_cmp += 2;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL syn_partial_count: %0d bytes missing, required 0", exp_q.size());
            exp_q.delete();
        end
        if (head_index_o !== 6'd0) begin
            n_err++; $display("FAIL syn_head: got %0d, required 0", head_index_o);
        end
        push_pkt(61, DLEN, 1'b1);
        readclk = 1'b1;
        wait_empty("syn_new", 3000);
        n_cmp++;
        if (head_index_o !== 6'd1) begin
            n_err++; $display("FAIL syn_new_head: got %0d, required 1", head_index_o);
        end
    endtask

    initial begin
        #990_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(1);
        test_reset();
        test_in_order();
        test_reorder();
        test_dup_window();
        test_wrap();
        test_truncated();
        test_syn_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ffcp_rx_reorder.md
# ffcp_rx_reorder

Receive-side FFCP payload reorder buffer, sitting between `ffcp_rx` and the downstream FGP consumer. It stores every in-window message payload in a per-index slot, even when the payload arrives out of order. It drains completed slots strictly in index order as a byte stream. It is the reader-side counterpart of the transmit packet buffer managed by `ffcp_tx_queue`/`ffcp_tx_server`.

## Interface
Parameters:
- `DATA_LEN`, default `FFCP_DATA_LEN` (769): payload bytes per message.
- `WINDOW_LEN`, default `FFCP_WINDOW_LEN` (8): number of slots. Must be a power of two.
- `RAM_LATENCY`, default 2: read latency of the slot RAM, in cycles.

Ports:
- `clk`: in, 1. System clock.
- `rst`: in, 1. Reset, synchronous, active-high.
- `metadata_inclk`: in, 1. Pulse carrying the type and index of the current packet (from `ffcp_rx.metadata_outclk`).
- `in_type`: in, `FFCP_TYPE_LEN`. Packet type.
- `in_index`: in, `FFCP_INDEX_LEN`. Packet index.
- `inclk`: in, 1. Payload byte strobe.
- `in`: in, `BYTE_LEN`. Payload byte.
- `in_done`: in, 1. Last payload byte strobe (from `ffcp_rx.done`). Coincides with the final `inclk`.
- `readclk`: in, 1. Downstream request for one byte.
- `rdy`: out, 1. High while a packet is being drained.
- `outclk`: out, 1. Output byte strobe.
- `out`: out, `BYTE_LEN`. Output byte.
- `out_done`: out, 1. Asserted together with `outclk` on the last byte of a packet.
- `head_index`: out, `FFCP_INDEX_LEN`. Index of the next packet to deliver.

## Operation
Reset: all `valid` bits are 0, `head_index`=0, state is IDLE, and the write accept flag is 0. `rdy`, `outclk`, `out_done` and `out` are all 0.

Slot mapping:
- `slot = index[clog2(WINDOW_LEN)-1:0]`.
- RAM address = `{slot, cnt[9:0]}`. The slot stride is 1024 bytes, so no multiplier is needed.

On `metadata_inclk`:
- SYN:
  - Clear all `valid` bits in one cycle.
  - `head_index` ← 0.
  - If a drain is in progress, abort it and flush the output delay line.
  - Accept the payload as index 0.
- MSG: accept iff both hold:
  - `(in_index - head_index) mod 2^FFCP_INDEX_LEN < WINDOW_LEN`;
  - `!valid[slot]`.
  
  Otherwise the packet is a duplicate or out of window; set accept=0 and ignore its payload.
- ACK or other types: accept=0.
- In every case the write counter `wcnt` ← 0.

Write path:
- Each `inclk` with accept=1 writes `in` to `{wslot, wcnt}`, then `wcnt`++.
- On `in_done` with accept=1 and `wcnt==DATA_LEN-1`: set `valid[wslot]` and clear accept.
- On `in_done` with any other count (truncated packet): clear accept, and leave `valid` unchanged.

Drain FSM:
- IDLE → DRAIN when `valid[head slot]`. At the same time `rcnt` ← 0.
- In DRAIN, each `readclk` issues a RAM read of `{head slot, rcnt}`, then `rcnt`++.
- On the `readclk` with `rcnt==DATA_LEN-1`:
  - `valid[head slot]` ← 0;
  - `head_index`++ (wraps modulo 64);
  - → IDLE.
- `readclk` in IDLE is ignored.

## Timing
- `valid` is set on the cycle after `in_done`. IDLE→DRAIN occurs on the next cycle, so `rdy` rises 2 cycles after the `in_done` of the head packet.
- `outclk`/`out`/`out_done` follow the matching `readclk` by exactly `RAM_LATENCY` cycles.
- `readclk` may be asserted every cycle, giving a throughput of 1 byte per cycle.
- Simultaneous completing write and drain end:
  - The write goes to a non-head slot, because the head slot is valid during a drain, so there is no conflict.
  - A write completion into the new head slot in the same cycle that the drain ends is seen by IDLE on the following cycle.
- `head_index` wrap: 63 → 0. Window comparisons use modulo-64 subtraction.
- `rst` or SYN during a drain: the bytes already in flight are suppressed, and no `out_done` is emitted for the aborted packet.

## Structure
- `FFCP_DATA_LEN`, `FFCP_WINDOW_LEN`, `FFCP_TYPE_*`, `FFCP_INDEX_LEN`, `BYTE_LEN` and `clog2` come from `networking.vh`. No new shared constants are needed.
- Sub-module `ffcp_rx_reorder_ram`: simple dual-port byte RAM of depth `WINDOW_LEN*1024`, with registered read of latency `RAM_LATENCY`.
- Output valid/done alignment reuses `delay`, reset by `rst || syn`.

## Test plan
- In-order delivery: SYN carrying index 0, then MSG index 1, each with a 769-byte ramp payload, with `readclk` held high. Required: 1538 `outclk` strobes in order, `out_done` on bytes 768 and 1537, final `head_index`=2.
- Reordering: after SYN/index 0 is drained, send MSG 3, then 2, then 1. Required: `rdy` stays low until index 1 completes, then indices 1, 2, 3 drain back-to-back; `head_index`=4.
- Duplicate and out-of-window: with `head_index`=4, send MSG 2 and MSG 12. Required: both ignored, RAM unchanged, no `rdy`. A duplicate of an already-buffered index 5 does not overwrite slot 5.
- Wraparound: advance `head_index` to 62, then send 63, 0 and 1. Required: delivered in order 62, 63, 0, 1; `head_index`=2.
- Truncated packet: `in_done` at `wcnt`=100. Required: slot not marked valid and no output.
- SYN mid-drain: assert SYN after 300 of 769 bytes have been read. Required:
  - no further bytes from the old packet and no `out_done` for it;
  - `head_index`=0;
  - the new index 0 payload is delivered intact.
